// File: rtl/tipi_xfer_ctrl.sv
// Sequencer for the four CPLD shift registers (RD/RC write, TD/TC read) with round-robin arbitration.
// Optional macro TIPI_XFER_CHANGE_DETECT_EN adds per-register change flags on TD/TC reads.
module tipi_xfer_ctrl #(
  parameter int DIV   = 2,
  parameter int SETUP = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [0:3] req,
  input  logic [0:7] wdata_rd,
  input  logic [0:7] wdata_rc,
  output logic [0:3] ack,
  output logic [0:7] rdata,
  output logic       busy,
  output logic [0:1] chg,
  output logic       r_clk,
  output logic       r_le,
  output logic       r_rt,
  output logic       r_dc,
  output logic       r_dout,
  input  logic       r_din
);

  // state | meaning
  // IDLE: arbitrate | SEL: hold r_rt/r_dc | LOAD: TD/TC parallel load | SHIFT: 8 bits | LATCH: RD/RC update | DONE: ack
  typedef enum logic [2:0] {S_IDLE, S_SEL, S_LOAD, S_SHIFT, S_LATCH, S_DONE} state_t;

  localparam int CMAX = (DIV > SETUP) ? DIV : SETUP;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
  localparam logic [CW-1:0] SETUP_M1 = CW'(SETUP - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q;
  logic [1:0]    ptr_q, idx_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          ph_q;
  logic [0:7]    sh_q;
  logic [0:3]    ack_q;
  logic [0:7]    rdata_q;
  logic          busy_q, r_clk_q, r_le_q, r_rt_q, r_dc_q, r_dout_q;
  logic          gnt_vld;
  logic [1:0]    gnt_idx;

`ifdef TIPI_XFER_CHANGE_DETECT_EN
  logic [0:1] chg_q;
  logic [0:7] last_q [0:1];
`endif

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr_q + 2'(i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = ptr_q + 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      ph_q     <= 1'b0;
      sh_q     <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      r_clk_q  <= 1'b0;
      r_le_q   <= 1'b0;
      r_rt_q   <= 1'b0;
      r_dc_q   <= 1'b0;
      r_dout_q <= 1'b0;
`ifdef TIPI_XFER_CHANGE_DETECT_EN
      chg_q     <= '0;
      last_q[0] <= '0;
      last_q[1] <= '0;
`endif
    end else begin
      ack_q <= '0;
`ifdef TIPI_XFER_CHANGE_DETECT_EN
      chg_q <= '0;
`endif
      case (state_q)
        S_IDLE: begin
          if (gnt_vld) begin
            state_q <= S_SEL;
            idx_q   <= gnt_idx;
            ptr_q   <= gnt_idx + 2'd1;
            cnt_q   <= SETUP_M1;
            busy_q  <= 1'b1;
            r_rt_q  <= gnt_idx[1];
            r_dc_q  <= gnt_idx[0];
            sh_q    <= gnt_idx[0] ? wdata_rc : wdata_rd;
          end
        end
        S_SEL: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            ph_q  <= 1'b0;
            bit_q <= '0;
            if (idx_q[1]) begin
              state_q <= S_LOAD;
              r_le_q  <= 1'b1;
            end else begin
              state_q  <= S_SHIFT;
              r_dout_q <= sh_q[0];
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_LOAD: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (!ph_q) begin
              ph_q   <= 1'b1;
              r_le_q <= 1'b0;
            end else begin
              ph_q    <= 1'b0;
              state_q <= S_SHIFT;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_SHIFT: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (!ph_q) begin
              ph_q    <= 1'b1;
              r_clk_q <= 1'b1;
              sh_q    <= {sh_q[1:7], r_din};
            end else begin
              ph_q    <= 1'b0;
              r_clk_q <= 1'b0;
              if (bit_q == 3'd7) begin
                if (idx_q[1]) begin
                  state_q       <= S_DONE;
                  ack_q[idx_q]  <= 1'b1;
                  rdata_q       <= sh_q;
`ifdef TIPI_XFER_CHANGE_DETECT_EN
                  chg_q[idx_q[0]]  <= (sh_q != last_q[idx_q[0]]);
                  last_q[idx_q[0]] <= sh_q;
`endif
                end else begin
                  state_q <= S_LATCH;
                end
              end else begin
                bit_q <= bit_q + 3'd1;
                if (!idx_q[1]) r_dout_q <= sh_q[0];
              end
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_LATCH: begin
          if (cnt_q == '0) begin
            cnt_q <= DIV_M1;
            if (!ph_q) begin
              ph_q   <= 1'b1;
              r_le_q <= 1'b1;
            end else begin
              ph_q         <= 1'b0;
              r_le_q       <= 1'b0;
              state_q      <= S_DONE;
              ack_q[idx_q] <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          r_rt_q   <= 1'b0;
          r_dc_q   <= 1'b0;
          r_dout_q <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ack    = ack_q;
  assign rdata  = rdata_q;
  assign busy   = busy_q;
  assign r_clk  = r_clk_q;
  assign r_le   = r_le_q;
  assign r_rt   = r_rt_q;
  assign r_dc   = r_dc_q;
  assign r_dout = r_dout_q;
`ifdef TIPI_XFER_CHANGE_DETECT_EN
  assign chg = chg_q;
`else
  assign chg = 2'b00;
`endif

endmodule
